spi_top: RTL and testbench

SPI_TOP -- requirements
Module: spi_top

---
 rtl/spi_top_pkg.sv | 46 ++++
 rtl/spi_byte_tx.sv | 73 +++++++
 rtl/spi_top.sv | 164 ++++++++++++++++
 tb/tb_spi_top.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/spi_top_pkg.sv
// Shared opcodes, FSM state type and the address-window byte helper for the
// ST7789-style panel initialiser.
package spi_top_pkg;

  localparam logic [7:0] CMD_SWRST  = 8'h01;
  localparam logic [7:0] CMD_SLPOUT = 8'h11;
  localparam logic [7:0] CMD_PIXFMT = 8'h3A;
  localparam logic [7:0] DAT_PIXFMT = 8'h55;
  localparam logic [7:0] CMD_INVON  = 8'h21;
  localparam logic [7:0] CMD_DISPON = 8'h29;
  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_PASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;

  typedef enum logic [3:0] {
    ST_HWRST,
    ST_HWWAIT,
    ST_SWRST,
    ST_WAIT1,
    ST_SLPOUT,
    ST_WAIT2,
    ST_PIXFMT,
    ST_INVON,
    ST_DISPON,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_PIXELS,
    ST_DONE
  } state_t;

  // Returns {dc, byte} for byte idx of a CASET/PASET transaction.
  function automatic logic [8:0] addr_byte(input logic [7:0]  cmd,
                                           input logic [15:0] start,
                                           input logic [15:0] stop,
                                           input logic [2:0]  idx);
    case (idx)
      3'd0:    addr_byte = {1'b0, cmd};
      3'd1:    addr_byte = {1'b1, start[15:8]};
      3'd2:    addr_byte = {1'b1, start[7:0]};
      3'd3:    addr_byte = {1'b1, stop[15:8]};
      default: addr_byte = {1'b1, stop[7:0]};
    endcase
  endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// Shifts one byte out MSB first, one bit per clock, with chip select low for
// exactly eight cycles; done_o pulses on the cycle CS returns high.
module spi_byte_tx (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  input  logic       dc_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       mosi_o,
  output logic       cs_o,
  output logic       dc_o
);

  logic [6:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic       mosi_q, mosi_d;
  logic       cs_q, cs_d;
  logic       dc_q, dc_d;
  logic       done_q, done_d;

  always_comb begin
    shift_d = shift_q;
    bit_d   = bit_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    dc_d    = dc_q;
    done_d  = 1'b0;
    if (cs_q) begin
      if (start_i) begin
        cs_d    = 1'b0;
        mosi_d  = byte_i[7];
        shift_d = byte_i[6:0];
        dc_d    = dc_i;
        bit_d   = 3'd0;
      end
    end else if (bit_q == 3'd7) begin
      cs_d   = 1'b1;
      mosi_d = 1'b0;
      done_d = 1'b1;
    end else begin
      mosi_d  = shift_q[6];
      shift_d = {shift_q[5:0], 1'b0};
      bit_d   = bit_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      bit_q   <= '0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      dc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bit_q   <= bit_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      dc_q    <= dc_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = ~cs_q;
  assign done_o = done_q;
  assign mosi_o = mosi_q;
  assign cs_o   = cs_q;
  assign dc_o   = dc_q;

endmodule

// File: rtl/spi_top.sv
// Panel bring-up sequencer: reset, init commands, then fills one square.
// Define SPI_TOP_INVERT_EN to insert display-inversion-on (0x21) before DISPON.
module spi_top
  import spi_top_pkg::*;
#(
  parameter int          DELAY   = 20,
  parameter logic [15:0] SQ_X    = 16'd16,
  parameter logic [15:0] SQ_Y    = 16'd16,
  parameter int          SQ_SIZE = 8,
  parameter logic [15:0] COLOR   = 16'hF800
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_mosi,
  output logic o_cs,
  output logic o_dc,
  output logic o_rst
);

  // DELAY must fit the 16-bit wait counter; SQ_SIZE <= 240 keeps pixels < 2^17.
  localparam logic [15:0] DLY_LAST = 16'(DELAY - 1);
  localparam logic [16:0] PIX_LAST = 17'(SQ_SIZE * SQ_SIZE - 1);
  localparam logic [15:0] X_END    = 16'(SQ_X + SQ_SIZE - 1);
  localparam logic [15:0] Y_END    = 16'(SQ_Y + SQ_SIZE - 1);

  state_t      state_q, state_d, next_s;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [16:0] pix_q, pix_d;
  logic        lo_q, lo_d;
  logic        pend_q, pend_d;
  logic        rst_q, rst_d;

  logic       tx_start, tx_busy, tx_done;
  logic [8:0] tx_word;
  logic       last, is_wait, is_send;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    pix_d    = pix_q;
    lo_d     = lo_q;
    pend_d   = pend_q;
    rst_d    = rst_q;
    tx_start = 1'b0;
    tx_word  = 9'h000;
    last     = 1'b1;
    next_s   = state_q;
    is_wait  = 1'b0;
    is_send  = 1'b0;

    case (state_q)
      ST_HWRST:  begin is_wait = 1'b1; next_s = ST_HWWAIT; end
      ST_HWWAIT: begin is_wait = 1'b1; next_s = ST_SWRST;  end
      ST_SWRST:  begin is_send = 1'b1; tx_word = {1'b0, CMD_SWRST};  next_s = ST_WAIT1; end
      ST_WAIT1:  begin is_wait = 1'b1; next_s = ST_SLPOUT; end
      ST_SLPOUT: begin is_send = 1'b1; tx_word = {1'b0, CMD_SLPOUT}; next_s = ST_WAIT2; end
      ST_WAIT2:  begin is_wait = 1'b1; next_s = ST_PIXFMT; end
      ST_PIXFMT: begin
        is_send = 1'b1;
        tx_word = (idx_q == 3'd0) ? {1'b0, CMD_PIXFMT} : {1'b1, DAT_PIXFMT};
        last    = (idx_q == 3'd1);
`ifdef SPI_TOP_INVERT_EN
        next_s  = ST_INVON;
`else
        next_s  = ST_DISPON;
`endif
      end
`ifdef SPI_TOP_INVERT_EN
      ST_INVON:  begin is_send = 1'b1; tx_word = {1'b0, CMD_INVON};  next_s = ST_DISPON; end
`endif
      ST_DISPON: begin is_send = 1'b1; tx_word = {1'b0, CMD_DISPON}; next_s = ST_CASET; end
      ST_CASET: begin
        is_send = 1'b1;
        tx_word = addr_byte(CMD_CASET, SQ_X, X_END, idx_q);
        last    = (idx_q == 3'd4);
        next_s  = ST_PASET;
      end
      ST_PASET: begin
        is_send = 1'b1;
        tx_word = addr_byte(CMD_PASET, SQ_Y, Y_END, idx_q);
        last    = (idx_q == 3'd4);
        next_s  = ST_RAMWR;
      end
      ST_RAMWR:  begin is_send = 1'b1; tx_word = {1'b0, CMD_RAMWR}; next_s = ST_PIXELS; end
      ST_PIXELS: begin
        is_send = 1'b1;
        tx_word = lo_q ? {1'b1, COLOR[7:0]} : {1'b1, COLOR[15:8]};
        last    = lo_q && (pix_q == PIX_LAST);
        next_s  = ST_DONE;
      end
      ST_DONE: ;
      default: state_d = ST_HWRST;
    endcase

    // Shared delay counter; cleared on every exit so it never wraps.
    if (is_wait) begin
      if (cnt_q == DLY_LAST) begin
        cnt_d   = 16'd0;
        state_d = next_s;
        if (state_q == ST_HWRST) rst_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    // One byte in flight at a time: issue, then wait for the done pulse.
    if (is_send) begin
      if (!pend_q && !tx_busy) begin
        tx_start = 1'b1;
        pend_d   = 1'b1;
      end else if (pend_q && tx_done) begin
        pend_d = 1'b0;
        if (state_q == ST_PIXELS) begin
          lo_d = ~lo_q;
          if (lo_q && !last) pix_d = pix_q + 17'd1;
        end
        if (last) begin
          idx_d   = 3'd0;
          state_d = next_s;
        end else if (state_q != ST_PIXELS) begin
          idx_d = idx_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_HWRST;
      cnt_q   <= '0;
      idx_q   <= '0;
      pix_q   <= '0;
      lo_q    <= 1'b0;
      pend_q  <= 1'b0;
      rst_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
      rst_q   <= rst_d;
    end
  end

  spi_byte_tx u_tx (
    .clk_i   (i_clk),
    .rst_ni  (i_rst),
    .start_i (tx_start),
    .byte_i  (tx_word[7:0]),
    .dc_i    (tx_word[8]),
    .busy_o  (tx_busy),
    .done_o  (tx_done),
    .mosi_o  (o_mosi),
    .cs_o    (o_cs),
    .dc_o    (o_dc)
  );

  assign o_rst = rst_q;

endmodule

// File: tb/tb_spi_top.sv
// Directed bench: decodes the serial stream of two configurations and checks
// reset values, reset timing, byte order, pixel payload and mid-frame reset.
module tb_spi_top;

  logic clk;
  logic rst_n;
  logic mosi0, cs0, dc0, prst0;
  logic mosi1, cs1, dc1, prst1;

  int checks;
  int errors;
  int dc_err0, idle_err0, dc_err1, idle_err1;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] hdr0[$];
  logic [8:0] hdr1[$];

  spi_top #(.DELAY(20), .SQ_X(16'd16), .SQ_Y(16'd16), .SQ_SIZE(8), .COLOR(16'hF800)) dut0 (
    .i_clk(clk), .i_rst(rst_n), .o_mosi(mosi0), .o_cs(cs0), .o_dc(dc0), .o_rst(prst0)
  );

  spi_top #(.DELAY(4), .SQ_X(16'h0100), .SQ_Y(16'h00FF), .SQ_SIZE(1), .COLOR(16'h07E0)) dut1 (
    .i_clk(clk), .i_rst(rst_n), .o_mosi(mosi1), .o_cs(cs1), .o_dc(dc1), .o_rst(prst1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin : mon0
    logic [7:0] sh;
    int nb;
    logic dcf;
    sh = 8'h00; nb = 0; dcf = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) nb = 0;
      else if (cs0 === 1'b0) begin
        if (nb == 0) dcf = dc0;
        else if (dc0 !== dcf) dc_err0++;
        sh = {sh[6:0], mosi0};
        nb++;
        if (nb == 8) begin q0.push_back({dcf, sh}); nb = 0; end
      end else begin
        nb = 0;
        if (mosi0 !== 1'b0) idle_err0++;
      end
    end
  end

  initial begin : mon1
    logic [7:0] sh;
    int nb;
    logic dcf;
    sh = 8'h00; nb = 0; dcf = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) nb = 0;
      else if (cs1 === 1'b0) begin
        if (nb == 0) dcf = dc1;
        else if (dc1 !== dcf) dc_err1++;
        sh = {sh[6:0], mosi1};
        nb++;
        if (nb == 8) begin q1.push_back({dcf, sh}); nb = 0; end
      end else begin
        nb = 0;
        if (mosi1 !== 1'b0) idle_err1++;
      end
    end
  end

  task automatic release_and_time(input string tag);
    int low;
    low = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    while (prst0 === 1'b0 && low < 200) begin
      @(negedge clk);
      if (prst0 === 1'b0) low++;
    end
    chk(tag, low, 20);
  endtask

  task automatic wait_q0(input int n, input int budget);
    int k;
    k = 0;
    while (q0.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_bytes", (q0.size() >= n) ? 1 : 0, 1);
  endtask

  initial begin
    checks = 0; errors = 0;
    dc_err0 = 0; idle_err0 = 0; dc_err1 = 0; idle_err1 = 0;
    rst_n = 1'b0;

    hdr0 = {9'h001, 9'h011, 9'h03A, 9'h155};
    hdr1 = {9'h001, 9'h011, 9'h03A, 9'h155};
`ifdef SPI_TOP_INVERT_EN
    hdr0.push_back(9'h021);
    hdr1.push_back(9'h021);
`endif
    hdr0 = {hdr0, 9'h029, 9'h02A, 9'h100, 9'h110, 9'h100, 9'h117,
            9'h02B, 9'h100, 9'h110, 9'h100, 9'h117, 9'h02C};
    hdr1 = {hdr1, 9'h029, 9'h02A, 9'h101, 9'h100, 9'h101, 9'h100,
            9'h02B, 9'h100, 9'h1FF, 9'h100, 9'h1FF, 9'h02C, 9'h107, 9'h1E0};

    // Outputs while held in reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", cs0, 1);
    chk("rst_mosi", mosi0, 0);
    chk("rst_dc", dc0, 0);
    chk("rst_prst", prst0, 0);

    release_and_time("hwrst_low");

    // Command header, then the pixel payload
    wait_q0(hdr0.size(), 3000);
    for (int i = 0; i < hdr0.size(); i++) chk($sformatf("hdr0[%0d]", i), q0[i], hdr0[i]);
    wait_q0(hdr0.size() + 128, 3000);
    for (int i = 0; i < 128; i++)
      chk($sformatf("pix0[%0d]", i), q0[hdr0.size() + i], (i % 2 == 0) ? 9'h1F8 : 9'h100);

    // Nothing more after the last pixel
    repeat (60) @(negedge clk);
    chk("total0", q0.size(), hdr0.size() + 128);
    chk("done_cs", cs0, 1);
    chk("done_dc", dc0, 1);
    chk("done_mosi", mosi0, 0);
    chk("done_prst", prst0, 1);
    chk("dc_stable0", dc_err0, 0);
    chk("idle_mosi0", idle_err0, 0);

    // Single-pixel square with end column == start column
    chk("total1", q1.size(), hdr1.size());
    for (int i = 0; i < hdr1.size(); i++) chk($sformatf("seq1[%0d]", i), q1[i], hdr1[i]);
    chk("dc_stable1", dc_err1, 0);
    chk("idle_mosi1", idle_err1, 0);

    // Restart, then reset in the middle of the pixel stream
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    q0.delete(); q1.delete();
    release_and_time("hwrst_low_2");
    wait_q0(hdr0.size() + 9, 3000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs", cs0, 1);
    chk("abort_mosi", mosi0, 0);
    chk("abort_dc", dc0, 0);
    chk("abort_prst", prst0, 0);
    repeat (3) @(posedge clk);
    q0.delete(); q1.delete();
    release_and_time("hwrst_low_3");
    wait_q0(hdr0.size(), 3000);
    for (int i = 0; i < hdr0.size(); i++) chk($sformatf("rehdr0[%0d]", i), q0[i], hdr0[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
